// File: rtl/hpi_pkg.sv
// hpi_pkg
// Shared definitions for the HPI target responder: the host-visible
// register select encoding and the STATUS register bit positions.
package hpi_pkg;

    // Register select as presented on hpi_address.
    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_e;

    // STATUS bit positions.
    localparam int ST_H2C = 0;
    localparam int ST_C2H = 1;
    localparam int ST_ERR = 2;

endpackage

// File: rtl/hpi_word_ram.sv
// hpi_word_ram
// Single-port MEM_WORDS x 16 synchronous RAM backing the HPI DATA window.
// Write-enabled store and a read port registered under i_re, so the last
// fetched word stays on o_rdata until the next read.
//   Clk      system clock
//   i_we     write enable
//   i_re     read enable (loads o_rdata)
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  registered read data
module hpi_word_ram #(
    parameter int unsigned  MEM_WORDS = 1024,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          Clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_wdata,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [MEM_WORDS];

    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/hpi_target_responder.sv
// hpi_target_responder
// Chip-side end of the host-port interface: address pointer, auto-incrementing
// DATA window onto a local word RAM, bidirectional mailbox and STATUS.
//   Clk, Reset            system clock, async active-high reset
//   hpi_cs_n/r_n/w_n      host strobes (active low, synchronous to Clk)
//   hpi_reset_n           host soft reset (active low, synchronous)
//   hpi_address           register select
//   hpi_data_in/out, oe   host data path
//   mbx_h2c_*             host-to-chip mailbox, local side
//   mbx_c2h_*             chip-to-host mailbox, local side
module hpi_target_responder
    import hpi_pkg::*;
#(
    parameter int unsigned  MEM_WORDS = 1024,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic        hpi_reset_n,
    input  logic [1:0]  hpi_address,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic [15:0] mbx_h2c_data,
    output logic        mbx_h2c_valid,
    input  logic        mbx_h2c_ack,
    input  logic [15:0] mbx_c2h_data,
    input  logic        mbx_c2h_push
);

    logic        r_cs_n, r_r_n, r_w_n;
    hpi_reg_e    r_addr;
    logic [15:0] r_din;
    logic        r_rd_lvl_d, r_wr_lvl_d;
    logic        r_armed;

    logic [15:0] r_ptr, r_c2h, r_h2c, r_dout;
    logic        r_h2c_full, r_c2h_full, r_err, r_oe, r_dout_ram;

    logic        w_rd_lvl, w_wr_lvl, w_coll, w_rd_start, w_wr_start;
    logic        w_ram_we, w_ram_re;
    logic [15:0] w_ram_q;
    logic [15:0] w_status;

    // Input stage. Not cleared by the soft reset so the edge history keeps
    // tracking the pins while it is asserted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cs_n     <= 1'b1;
            r_r_n      <= 1'b1;
            r_w_n      <= 1'b1;
            r_addr     <= HPI_DATA;
            r_din      <= '0;
            r_rd_lvl_d <= 1'b0;
            r_wr_lvl_d <= 1'b0;
        end else begin
            r_cs_n     <= hpi_cs_n;
            r_r_n      <= hpi_r_n;
            r_w_n      <= hpi_w_n;
            r_addr     <= hpi_reg_e'(hpi_address);
            r_din      <= hpi_data_in;
            r_rd_lvl_d <= w_rd_lvl;
            r_wr_lvl_d <= w_wr_lvl;
        end
    end

    // Starts are only accepted once the pins have been seen idle after any
    // reset, so a strobe held low across reset is dropped, not replayed.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_armed <= 1'b0;
        end else if (!hpi_reset_n) begin
            r_armed <= 1'b0;
        end else if (hpi_cs_n || (hpi_r_n && hpi_w_n)) begin
            r_armed <= 1'b1;
        end
    end

    assign w_rd_lvl   = !r_cs_n && !r_r_n;
    assign w_wr_lvl   = !r_cs_n && !r_w_n;
    assign w_coll     = w_rd_lvl && w_wr_lvl;
    assign w_rd_start = hpi_reset_n && r_armed && w_rd_lvl && !r_rd_lvl_d && !w_coll;
    assign w_wr_start = hpi_reset_n && r_armed && w_wr_lvl && !r_wr_lvl_d && !w_coll;

    assign w_ram_we = w_wr_start && (r_addr == HPI_DATA);
    assign w_ram_re = w_rd_start && (r_addr == HPI_DATA);

    always_comb begin
        w_status         = '0;
        w_status[ST_H2C] = r_h2c_full;
        w_status[ST_C2H] = r_c2h_full;
        w_status[ST_ERR] = r_err;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr      <= '0;
            r_c2h      <= '0;
            r_h2c      <= '0;
            r_dout     <= '0;
            r_h2c_full <= 1'b0;
            r_c2h_full <= 1'b0;
            r_err      <= 1'b0;
            r_oe       <= 1'b0;
            r_dout_ram <= 1'b0;
        end else if (!hpi_reset_n) begin
            r_ptr      <= '0;
            r_c2h      <= '0;
            r_h2c      <= '0;
            r_dout     <= '0;
            r_h2c_full <= 1'b0;
            r_c2h_full <= 1'b0;
            r_err      <= 1'b0;
            r_oe       <= 1'b0;
            r_dout_ram <= 1'b0;
        end else begin
            r_oe <= r_armed && !r_cs_n && !r_r_n && r_w_n;

            if (w_coll) begin
                r_err <= 1'b1;
            end

            // Ack first so a same-cycle host write keeps the box full.
            if (mbx_h2c_ack) begin
                r_h2c_full <= 1'b0;
            end

            if (w_wr_start) begin
                case (r_addr)
                    HPI_ADDRESS: r_ptr <= r_din;
                    HPI_DATA:    r_ptr <= r_ptr + 16'd2;
                    HPI_MAILBOX: begin
                        r_h2c      <= r_din;
                        r_h2c_full <= 1'b1;
                    end
                    HPI_STATUS: begin
                        if (r_din[ST_ERR]) begin
                            r_err <= 1'b0;
                        end
                    end
                endcase
            end

            if (w_rd_start) begin
                r_dout_ram <= (r_addr == HPI_DATA);
                case (r_addr)
                    HPI_DATA:    r_ptr <= r_ptr + 16'd2;
                    HPI_MAILBOX: begin
                        r_dout     <= r_c2h;
                        r_c2h_full <= 1'b0;
                    end
                    HPI_ADDRESS: r_dout <= r_ptr;
                    HPI_STATUS:  r_dout <= w_status;
                endcase
            end

            // Push after the read so a colliding push re-fills the box.
            if (mbx_c2h_push) begin
                r_c2h      <= mbx_c2h_data;
                r_c2h_full <= 1'b1;
            end
        end
    end

    hpi_word_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .Clk     (Clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (r_ptr[AW:1]),
        .i_wdata (r_din),
        .o_rdata (w_ram_q)
    );

    // DATA reads come straight from the RAM output register; everything
    // else from r_dout. r_dout_ram is cleared by reset so the port reads 0.
    assign hpi_data_out  = r_dout_ram ? w_ram_q : r_dout;
    assign hpi_data_oe   = r_oe;
    assign mbx_h2c_data  = r_h2c;
    assign mbx_h2c_valid = r_h2c_full;

endmodule

// File: tb/tb_hpi_target_responder.sv
module tb_hpi_target_responder;
    import hpi_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n;
    logic [1:0]  hpi_address;
    logic [15:0] hpi_data_in;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] mbx_h2c_data;
    logic        mbx_h2c_valid;
    logic        mbx_h2c_ack;
    logic [15:0] mbx_c2h_data;
    logic        mbx_c2h_push;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    always #5 Clk = ~Clk;

    hpi_target_responder #(.MEM_WORDS(1024)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .hpi_cs_n      (hpi_cs_n),
        .hpi_r_n       (hpi_r_n),
        .hpi_w_n       (hpi_w_n),
        .hpi_reset_n   (hpi_reset_n),
        .hpi_address   (hpi_address),
        .hpi_data_in   (hpi_data_in),
        .hpi_data_out  (hpi_data_out),
        .hpi_data_oe   (hpi_data_oe),
        .mbx_h2c_data  (mbx_h2c_data),
        .mbx_h2c_valid (mbx_h2c_valid),
        .mbx_h2c_ack   (mbx_h2c_ack),
        .mbx_c2h_data  (mbx_c2h_data),
        .mbx_c2h_push  (mbx_c2h_push)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        sb_t it;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty: observed %0d expected 1", sb.size());
        end else begin
            it = sb.pop_front();
            chk(it.tag, hpi_data_out, it.exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge Clk);
        hpi_cs_n = 1'b0; hpi_w_n = 1'b0; hpi_address = a; hpi_data_in = d;
        @(negedge Clk);
        hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
        sb.push_back('{tag, exp});
        @(negedge Clk);
        hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_address = a;
        @(negedge Clk);
        @(negedge Clk);
        pop_check();
        chk({tag, "_oe"}, {15'd0, hpi_data_oe}, 16'd1);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        hpi_reset_n = 1'b1; hpi_address = 2'd0; hpi_data_in = 16'd0;
        mbx_h2c_ack = 1'b0; mbx_c2h_data = 16'd0; mbx_c2h_push = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_dout",  hpi_data_out, 16'h0000);
        chk("rst_oe",    {15'd0, hpi_data_oe}, 16'd0);
        chk("rst_valid", {15'd0, mbx_h2c_valid}, 16'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Auto-incrementing DATA window
        wr(HPI_ADDRESS, 16'h0010);
        wr(HPI_DATA, 16'hA5A5);
        wr(HPI_DATA, 16'h5A5A);
        wr(HPI_ADDRESS, 16'h0010);
        rd(HPI_DATA, 16'hA5A5, "data0");
        rd(HPI_DATA, 16'h5A5A, "data1");
        rd(HPI_ADDRESS, 16'h0014, "ptr_after_reads");

        // Host-to-chip mailbox
        wr(HPI_MAILBOX, 16'h1234);
        chk("h2c_valid", {15'd0, mbx_h2c_valid}, 16'd1);
        chk("h2c_data", mbx_h2c_data, 16'h1234);
        rd(HPI_STATUS, 16'h0001, "status_h2c");
        @(negedge Clk); mbx_h2c_ack = 1'b1;
        @(negedge Clk); mbx_h2c_ack = 1'b0;
        chk("h2c_valid_ack", {15'd0, mbx_h2c_valid}, 16'd0);
        rd(HPI_STATUS, 16'h0000, "status_ack");

        // Chip-to-host mailbox
        @(negedge Clk); mbx_c2h_data = 16'hBEEF; mbx_c2h_push = 1'b1;
        @(negedge Clk); mbx_c2h_push = 1'b0;
        rd(HPI_STATUS, 16'h0002, "status_c2h");
        rd(HPI_MAILBOX, 16'hBEEF, "c2h_read");
        rd(HPI_STATUS, 16'h0000, "status_c2h_clr");

        // Pointer wrap and RAM aliasing
        wr(HPI_ADDRESS, 16'hFFFE);
        wr(HPI_DATA, 16'h0001);
        rd(HPI_ADDRESS, 16'h0000, "ptr_wrap");
        wr(HPI_ADDRESS, 16'h07FE);
        rd(HPI_DATA, 16'h0001, "alias_read");

        // Read/write collision
        wr(HPI_ADDRESS, 16'h0010);
        @(negedge Clk);
        hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
        hpi_address = HPI_DATA; hpi_data_in = 16'hFFFF;
        repeat (2) @(negedge Clk);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        rd(HPI_STATUS, 16'h0004, "status_err");
        rd(HPI_ADDRESS, 16'h0010, "coll_ptr");
        rd(HPI_DATA, 16'hA5A5, "coll_ram");
        wr(HPI_STATUS, 16'h0004);
        rd(HPI_STATUS, 16'h0000, "err_w1c");

        // Held strobe performs a single access
        wr(HPI_ADDRESS, 16'h0020);
        @(negedge Clk);
        hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_address = HPI_DATA;
        repeat (6) @(negedge Clk);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
        rd(HPI_ADDRESS, 16'h0022, "held_read_ptr");

        // Soft reset retains RAM
        wr(HPI_ADDRESS, 16'h0100);
        wr(HPI_DATA, 16'hCAFE);
        wr(HPI_ADDRESS, 16'h0100);
        wr(HPI_MAILBOX, 16'h7777);
        @(negedge Clk); hpi_reset_n = 1'b0;
        @(negedge Clk); hpi_reset_n = 1'b1;
        chk("srst_oe",    {15'd0, hpi_data_oe}, 16'd0);
        chk("srst_valid", {15'd0, mbx_h2c_valid}, 16'd0);
        chk("srst_h2c",   mbx_h2c_data, 16'h0000);
        chk("srst_dout",  hpi_data_out, 16'h0000);
        rd(HPI_ADDRESS, 16'h0000, "srst_ptr");
        rd(HPI_STATUS, 16'h0000, "srst_status");
        wr(HPI_ADDRESS, 16'h0100);
        rd(HPI_DATA, 16'hCAFE, "srst_ram_kept");

        // Async reset mid-read
        wr(HPI_ADDRESS, 16'h0042);
        @(negedge Clk);
        hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_address = HPI_ADDRESS;
        repeat (2) @(negedge Clk);
        chk("pre_arst_oe", {15'd0, hpi_data_oe}, 16'd1);
        #2 Reset = 1'b1;
        #1 chk("arst_oe", {15'd0, hpi_data_oe}, 16'd0);
        @(negedge Clk); Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("arst_no_replay_oe", {15'd0, hpi_data_oe}, 16'd0);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
        rd(HPI_ADDRESS, 16'h0000, "arst_ptr");

        repeat (2) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hpi_target_responder.md
Name: hpi_target_responder

Overview:
- Synthesizable responder for the host-port interface (HPI) that the SoC's OTG PIOs drive: 2-bit address, active-low chip-select, read, write and reset strobes, and split 16-bit data in/out.
- Acts as the chip end of the link: address pointer, auto-incrementing DATA window onto a local word RAM, bidirectional mailbox, STATUS register.
- Stands in for the USB controller in simulation and in loopback bring-up builds, and lets the NIOS HPI driver be exercised without the physical part.

Parameters:
- MEM_WORDS, 1024, depth of the local 16-bit word RAM (power of two, 16..32768).
- AW, $clog2(MEM_WORDS), RAM index width. Derived; do not override.

Ports:
- Clk  in  1  system clock. The HPI strobes are synchronous to it (driven by PIOs on the same clock).
- Reset  in  1  asynchronous, active-high reset.
- hpi_cs_n  in  1  chip select, active low.
- hpi_r_n  in  1  read strobe, active low.
- hpi_w_n  in  1  write strobe, active low.
- hpi_reset_n  in  1  HPI-side soft reset, active low, sampled synchronously.
- hpi_address  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- hpi_data_in  in  16  host-to-responder write data.
- hpi_data_out  out  16  responder-to-host read data.
- hpi_data_oe  out  1  high while the responder drives read data.
- mbx_h2c_data  out  16  last mailbox word written by the host.
- mbx_h2c_valid  out  1  high while the host-to-chip mailbox is unread.
- mbx_h2c_ack  in  1  local side consumed mbx_h2c_data.
- mbx_c2h_data  in  16  local word to post to the host.
- mbx_c2h_push  in  1  one-cycle strobe that posts mbx_c2h_data.

Behaviour:
- Input stage: cs_n, r_n, w_n and address are registered once. Previous-cycle copies are kept for edge detection.
- rd_start: the cycle where registered cs_n=0 and r_n=0, and the previous sample was not both low.
- wr_start: same rule using w_n.
- Collision: r_n and w_n both low with cs_n low means neither start fires and STATUS[2] (ERR) is set (sticky). ERR clears only on reset or a host write to STATUS with bit 2 = 1.
- Write commit happens on the wr_start cycle, using the hpi_data_in registered in that cycle:
  - ADDRESS: ptr <= data.
  - DATA: ram[ptr[AW:1]] <= data, then ptr <= ptr+2.
  - MAILBOX: mbx_h2c_data <= data, h2c_full <= 1.
  - STATUS: write-1-to-clear on bit 2 only.
- Read fetch happens on the rd_start cycle. hpi_data_out is valid one cycle later and holds until the next fetch:
  - DATA: ram[ptr[AW:1]], then ptr <= ptr+2.
  - MAILBOX: c2h register, and c2h_full is cleared.
  - ADDRESS: ptr.
  - STATUS: {13'b0, ERR, c2h_full, h2c_full}.
- hpi_data_oe = registered (cs_n=0 and r_n=0 and w_n=1). It rises in the same cycle hpi_data_out becomes valid and falls one cycle after r_n rises.
- Pointer:
  - 16-bit byte address; bit 0 is ignored for indexing.
  - Increments modulo 2^16 (0xFFFE -> 0x0000).
  - The RAM index aliases modulo MEM_WORDS.
- Mailboxes:
  - mbx_h2c_valid = h2c_full. mbx_h2c_ack clears it. If an ack and a host MAILBOX write land in the same cycle, the write wins and full stays 1 with the new data.
  - A second host write while full overwrites the data. No error is raised.
  - mbx_c2h_push loads c2h and sets c2h_full. If a push and a host MAILBOX read land in the same cycle, the host reads the old word, the new word loads, and c2h_full stays 1.
- Reset: Reset (async), or hpi_reset_n low (sync, priority over all host accesses) clears:
  - ptr, ERR, h2c_full, c2h_full, the c2h register, mbx_h2c_data;
  - hpi_data_out=0, hpi_data_oe=0, mbx_h2c_valid=0.
  
  RAM contents are retained. An access in progress when reset asserts is dropped; its start is not re-detected after release unless the strobes return high first.
- One access per strobe assertion. Holding a strobe low does not repeat the access or re-increment ptr.

Decomposition:
- hpi_pkg:
  - register offsets HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3;
  - STATUS bit positions ST_H2C=0, ST_C2H=1, ST_ERR=2;
  - a 2-bit enum typedef for the register select.
- Sub-module hpi_word_ram: single-port MEM_WORDS x 16 synchronous RAM with write enable and registered read (infers block RAM). The top keeps the strobe decode, pointer and mailbox logic.

Test Plan:
- Write ADDRESS=0x0010, then DATA 0xA5A5, 0x5A5A, then ADDRESS=0x0010 and read DATA twice -> returns 0xA5A5 then 0x5A5A; ADDRESS readback = 0x0014.
- Host writes MAILBOX 0x1234 -> mbx_h2c_valid=1, data 0x1234, STATUS read=0x0001. Pulse mbx_h2c_ack -> STATUS=0x0000.
- mbx_c2h_push with 0xBEEF -> STATUS=0x0002. MAILBOX read returns 0xBEEF, then STATUS=0x0000.
- ADDRESS=0xFFFE with MEM_WORDS=1024, DATA write 0x0001 -> ptr=0x0000, ram[1023]=0x0001; reading back from 0x07FE aliases to the same word.
- Assert r_n and w_n low together under cs_n -> no RAM/ptr change, STATUS=0x0004. Write STATUS 0x0004 -> STATUS=0x0000.
- Load ptr=0x0100 and set h2c_full, then pulse hpi_reset_n low -> ptr=0, STATUS=0, oe=0, RAM word at 0x0100 unchanged. Async Reset mid-read drops oe in the same cycle.
